// File: rtl/ahbl_ram_pkg.sv
// Shared AHB-Lite encodings and load-engine state encoding for ahbl_loadable_ram.
package ahbl_ram_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;
   localparam logic [1:0] ST_FLUSH = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_CLEAR = ST_CLEAR,
      S_LOAD  = ST_LOAD,
      S_FLUSH = ST_FLUSH
   } ld_state_e;

endpackage

// File: rtl/ahbl_byte_lane_dec.sv
// Byte-lane enable decode from registered HSIZE and low address bits; purely combinational.
// Sizes above a word enable no lanes, so such writes leave the array untouched.
module ahbl_byte_lane_dec
   import ahbl_ram_pkg::*;
(
   input  logic [2:0] hsize_i,
   input  logic [1:0] addr_i,
   output logic [3:0] be_o
);

   always_comb begin
      be_o = 4'b0000;
      case (hsize_i)
         HSIZE_BYTE: be_o = 4'b0001 << addr_i;
         HSIZE_HALF: be_o = addr_i[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: be_o = 4'b1111;
         default:    be_o = 4'b0000;
      endcase
   end

endmodule

// File: rtl/ahbl_loadable_ram.sv
// AHB-Lite word SRAM with WAIT_STATES data-phase waits and a clear-then-load byte engine; the bus
// stalls on HREADYOUT while the engine is busy. Define AHBL_RAM_CHKSUM_EN for the load checksum.
module ahbl_loadable_ram
   import ahbl_ram_pkg::*;
#(
   parameter int unsigned SIZE        = 65536,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned LOAD_BASE   = 0,
   parameter string       HEX_FILE    = ""
) (
   input  logic                    HCLK,
   input  logic                    HRESET,
   input  logic [31:0]             HADDR,
   input  logic [1:0]              HTRANS,
   input  logic                    HREADY,
   input  logic [2:0]              HSIZE,
   input  logic                    HWRITE,
   input  logic                    HSEL,
   input  logic [31:0]             HWDATA,
   output logic                    HREADYOUT,
   output logic [31:0]             HRDATA,
   output logic                    HRESP,
   input  logic                    ld_start,
   input  logic [7:0]              ld_data,
   input  logic                    ld_valid,
   output logic                    ld_ready,
   input  logic                    ld_end,
   output logic                    busy,
   output logic [$clog2(SIZE)-2:0] ld_words,
   output logic                    ld_ovf,
   output logic [15:0]             ld_chksum
);

   localparam int unsigned       A_WIDTH = $clog2(SIZE) - 2;
   localparam int unsigned       DEPTH   = SIZE / 4;
   localparam logic [1:0]        WS      = WAIT_STATES[1:0];
   localparam logic [A_WIDTH+1:0] BASE_W = LOAD_BASE[A_WIDTH+3:2];

   logic [31:0] mem [DEPTH];

   logic [A_WIDTH+1:0] haddr_q;
   logic [2:0]         hsize_q;
   logic               hwrite_q, hsel_q, htrans1_q;
   logic [1:0]         wait_q, wait_d;
   ld_state_e          state_q, state_d;
   logic [A_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
   logic [1:0]         lane_q, lane_d;
   logic [23:0]        buf_q, buf_d;
   logic [A_WIDTH:0]   words_q, words_d;
   logic               ovf_q, ovf_d;

   logic               dp_act, bus_commit, bus_we, ld_acc, ld_in_range;
   logic [3:0]         be;
   logic [31:0]        bmask, bus_merged;
   logic [A_WIDTH+1:0] ld_idx;
   logic               eng_we;
   logic [A_WIDTH-1:0] eng_idx;
   logic [31:0]        eng_dat;
   logic               unused_bits;

   assign unused_bits = &{1'b0, HADDR[31:A_WIDTH+2], HTRANS[0]};

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         haddr_q   <= '0;
         hsize_q   <= '0;
         hwrite_q  <= 1'b0;
         hsel_q    <= 1'b0;
         htrans1_q <= 1'b0;
      end else if (HREADY) begin
         haddr_q   <= HADDR[A_WIDTH+1:0];
         hsize_q   <= HSIZE;
         hwrite_q  <= HWRITE;
         hsel_q    <= HSEL;
         htrans1_q <= HTRANS[1];
      end
   end

   // The wait counter freezes while busy so the full wait sequence runs once busy drops.
   assign dp_act = hsel_q & htrans1_q;

   always_comb begin
      HREADYOUT  = 1'b1;
      wait_d     = wait_q;
      bus_commit = 1'b0;
      if (dp_act) begin
         if (busy) begin
            HREADYOUT = 1'b0;
         end else if (wait_q != WS) begin
            HREADYOUT = 1'b0;
            wait_d    = wait_q + 2'd1;
         end else begin
            wait_d     = 2'd0;
            bus_commit = 1'b1;
         end
      end
   end

   ahbl_byte_lane_dec u_lane_dec (
      .hsize_i (hsize_q),
      .addr_i  (haddr_q[1:0]),
      .be_o    (be)
   );

   assign bus_we     = bus_commit & hwrite_q;
   assign bmask      = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   assign HRDATA     = mem[haddr_q[A_WIDTH+1:2]];
   assign bus_merged = (HRDATA & ~bmask) | (HWDATA & bmask);
   assign HRESP      = 1'b0;

   assign busy        = (state_q != S_IDLE);
   assign ld_ready    = (state_q == S_LOAD);
   assign ld_acc      = ld_ready & ld_valid;
   assign ld_idx      = {1'b0, words_q} + BASE_W;
   assign ld_in_range = (ld_idx[A_WIDTH+1:A_WIDTH] == 2'b00);
   assign ld_words    = words_q;
   assign ld_ovf      = ovf_q;

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      lane_d    = lane_q;
      buf_d     = buf_q;
      words_d   = words_q;
      ovf_d     = ovf_q;
      eng_we    = 1'b0;
      eng_idx   = clr_ptr_q;
      eng_dat   = 32'h0;
      case (state_q)
         S_IDLE: begin
            if (ld_start) begin
               state_d   = S_CLEAR;
               clr_ptr_d = '0;
               lane_d    = 2'd0;
               buf_d     = '0;
               words_d   = '0;
               ovf_d     = 1'b0;
            end
         end
         S_CLEAR: begin
            eng_we = 1'b1;
            if (&clr_ptr_q) state_d = S_LOAD;
            else            clr_ptr_d = clr_ptr_q + 1'b1;
         end
         S_LOAD: begin
            if (ld_acc) begin
               lane_d = lane_q + 2'd1;
               case (lane_q)
                  2'd0: buf_d[7:0]   = ld_data;
                  2'd1: buf_d[15:8]  = ld_data;
                  2'd2: buf_d[23:16] = ld_data;
                  default: begin
                     buf_d = '0;
                     if (ld_in_range) begin
                        eng_we  = 1'b1;
                        eng_idx = ld_idx[A_WIDTH-1:0];
                        eng_dat = {ld_data, buf_q};
                        words_d = words_q + 1'b1;
                     end else begin
                        ovf_d = 1'b1;
                     end
                  end
               endcase
            end
            if (ld_end) state_d = (lane_d != 2'd0) ? S_FLUSH : S_IDLE;
         end
         S_FLUSH: begin
            // Lanes not yet received are already zero in buf_q.
            if (ld_in_range) begin
               eng_we  = 1'b1;
               eng_idx = ld_idx[A_WIDTH-1:0];
               eng_dat = {8'h00, buf_q};
               words_d = words_q + 1'b1;
            end else begin
               ovf_d = 1'b1;
            end
            lane_d  = 2'd0;
            buf_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q   <= S_IDLE;
         clr_ptr_q <= '0;
         lane_q    <= 2'd0;
         buf_q     <= '0;
         words_q   <= '0;
         ovf_q     <= 1'b0;
         wait_q    <= 2'd0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         lane_q    <= lane_d;
         buf_q     <= buf_d;
         words_q   <= words_d;
         ovf_q     <= ovf_d;
         wait_q    <= wait_d;
      end
   end

   // Engine and bus writes never coincide: the bus only commits while the engine is idle.
   always_ff @(posedge HCLK) begin
      if (eng_we)      mem[eng_idx] <= eng_dat;
      else if (bus_we) mem[haddr_q[A_WIDTH+1:2]] <= bus_merged;
   end

`ifdef AHBL_RAM_CHKSUM_EN
   logic [15:0] sum_q;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET)                              sum_q <= 16'h0000;
      else if ((state_q == S_IDLE) && ld_start) sum_q <= 16'h0000;
      else if (ld_acc)                         sum_q <= sum_q + {8'h00, ld_data};
   end

   assign ld_chksum = sum_q;
`else
   assign ld_chksum = 16'h0000;
`endif

endmodule

// File: tb/tb_ahbl_loadable_ram.sv
// Directed bench: instance A (SIZE=64, no waits, base 0), instance B (SIZE=64, 2 waits, base 0x38).
module tb_ahbl_loadable_ram;
   import ahbl_ram_pkg::*;

   logic        HCLK, HRESET;
   logic [31:0] HADDR, HWDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HWRITE, hsel, sel;
   logic [7:0]  ld_data;
   logic        ld_valid, ld_end, ld_start_a, ld_start_b;

   logic        hro_a, hro_b, hresp_a, hresp_b, ldr_a, ldr_b, busy_a, busy_b, ovf_a, ovf_b;
   logic [31:0] hrd_a, hrd_b;
   logic [4:0]  words_a, words_b;
   logic [15:0] sum_a, sum_b;
   logic        hsel_a, hsel_b, cur_hro, cur_ldr;
   logic [31:0] cur_hrd;

   int n_cmp = 0;
   int n_err = 0;
   int exp_ws;

   assign hsel_a  = hsel & ~sel;
   assign hsel_b  = hsel & sel;
   assign cur_hro = sel ? hro_b : hro_a;
   assign cur_hrd = sel ? hrd_b : hrd_a;
   assign cur_ldr = sel ? ldr_b : ldr_a;

   ahbl_loadable_ram #(.SIZE(64), .WAIT_STATES(0), .LOAD_BASE(0)) u_dut_a (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HREADY(hro_a),
      .HSIZE(HSIZE), .HWRITE(HWRITE), .HSEL(hsel_a), .HWDATA(HWDATA),
      .HREADYOUT(hro_a), .HRDATA(hrd_a), .HRESP(hresp_a),
      .ld_start(ld_start_a), .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ldr_a),
      .ld_end(ld_end), .busy(busy_a), .ld_words(words_a), .ld_ovf(ovf_a), .ld_chksum(sum_a)
   );

   ahbl_loadable_ram #(.SIZE(64), .WAIT_STATES(2), .LOAD_BASE(32'h38)) u_dut_b (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HREADY(hro_b),
      .HSIZE(HSIZE), .HWRITE(HWRITE), .HSEL(hsel_b), .HWDATA(HWDATA),
      .HREADYOUT(hro_b), .HRDATA(hrd_b), .HRESP(hresp_b),
      .ld_start(ld_start_b), .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ldr_b),
      .ld_end(ld_end), .busy(busy_b), .ld_words(words_b), .ld_ovf(ovf_b), .ld_chksum(sum_b)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ck(input logic [31:0] v);
`ifdef AHBL_RAM_CHKSUM_EN
      return v;
`else
      return 32'h0 & v;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus(input logic wr, input logic [31:0] addr, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int waits);
      @(posedge HCLK); #1;
      hsel = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = addr; HWRITE = wr; HSIZE = sz;
      @(posedge HCLK); #1;
      hsel = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = wd;
      waits = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge HCLK);
         if (cur_hro) break;
         waits++;
      end
      rd = cur_hrd;
   endtask

   task automatic wr(input string tag, input logic [31:0] addr, input logic [2:0] sz,
                     input logic [31:0] data);
      logic [31:0] r;
      int w;
      bus(1'b1, addr, sz, data, r, w);
      chk({tag, "_waits"}, 32'(w), 32'(exp_ws));
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] r;
      int w;
      bus(1'b0, addr, HSIZE_WORD, 32'h0, r, w);
      chk({tag, "_data"}, r, exp);
      chk({tag, "_waits"}, 32'(w), 32'(exp_ws));
   endtask

   task automatic wait_ready(input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge HCLK);
         if (cur_ldr) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, 32'(ok), 32'h1);
   endtask

   task automatic pulse_start();
      @(posedge HCLK); #1;
      if (sel) ld_start_b = 1'b1; else ld_start_a = 1'b1;
      @(posedge HCLK); #1;
      ld_start_a = 1'b0; ld_start_b = 1'b0;
   endtask

   initial begin
      int          clr, stall_bad, w0, w1;
      logic [31:0] rd0, rd1;

      HRESET = 1'b1; HADDR = '0; HWDATA = '0; HTRANS = HTRANS_IDLE; HSIZE = HSIZE_WORD;
      HWRITE = 1'b0; hsel = 1'b0; sel = 1'b0; ld_data = '0; ld_valid = 1'b0;
      ld_end = 1'b0; ld_start_a = 1'b0; ld_start_b = 1'b0; exp_ws = 0;
      repeat (3) @(posedge HCLK);
      #1 HRESET = 1'b0;
      @(negedge HCLK);
      chk("rst_hreadyout_a", 32'(hro_a), 32'h1);
      chk("rst_busy_a", 32'(busy_a), 32'h0);
      chk("rst_ld_ready_a", 32'(ldr_a), 32'h0);
      chk("rst_ld_words_a", 32'(words_a), 32'h0);
      chk("rst_ld_ovf_a", 32'(ovf_a), 32'h0);
      chk("rst_chksum_a", 32'(sum_a), 32'h0);
      chk("rst_hresp_a", 32'(hresp_a), 32'h0);
      chk("rst_hreadyout_b", 32'(hro_b), 32'h1);
      chk("rst_busy_b", 32'(busy_b), 32'h0);

      // Byte/half/word write lanes on A
      sel = 1'b0; exp_ws = 0;
      wr("w_word10", 32'h10, HSIZE_WORD, 32'hDEADBEEF);
      wr("w_byte12", 32'h12, HSIZE_BYTE, 32'h11553344);
      wr("w_word14", 32'h14, HSIZE_WORD, 32'h00000000);
      wr("w_half14", 32'h14, HSIZE_HALF, 32'h99991234);
      wr("w_word18", 32'h18, HSIZE_WORD, 32'h11111111);
      wr("w_half1a", 32'h1A, HSIZE_HALF, 32'hABCD5678);
      wr("w_dword18", 32'h18, 3'b011, 32'hFFFFFFFF);
      rd_chk("r_10", 32'h10, 32'hDE55BEEF);
      rd_chk("r_14", 32'h14, 32'h00001234);
      rd_chk("r_18", 32'h18, 32'hABCD1111);
      wr("w_byte11", 32'h11, HSIZE_BYTE, 32'h0000AA00);
      rd_chk("r_10b", 32'h10, 32'hDE55AAEF);

      // Clear with a read stalled behind it
      @(posedge HCLK); #1;
      ld_start_a = 1'b1;
      hsel = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h18; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
      @(posedge HCLK); #1;
      ld_start_a = 1'b0; hsel = 1'b0; HTRANS = HTRANS_IDLE;
      clr = 0; stall_bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge HCLK);
         if (ldr_a) break;
         clr++;
         if (hro_a) stall_bad++;
      end
      chk("clear_cycles", 32'(clr), 32'd16);
      chk("stall_in_clear", 32'(stall_bad), 32'd0);
      chk("stall_in_load", 32'(hro_a), 32'h0);
      chk("busy_in_load", 32'(busy_a), 32'h1);
      @(posedge HCLK); #1 ld_end = 1'b1;
      @(posedge HCLK); #1 ld_end = 1'b0;
      @(negedge HCLK);
      chk("stalled_rd_ready", 32'(hro_a), 32'h1);
      chk("stalled_rd_data", hrd_a, 32'h0);
      chk("busy_after_end", 32'(busy_a), 32'h0);
      chk("words_empty_load", 32'(words_a), 32'h0);

      // Five-byte stream ends with a partial word
      pulse_start();
      wait_ready("rdy_load5");
      for (int i = 1; i <= 5; i++) begin
         @(posedge HCLK); #1;
         ld_valid = 1'b1; ld_data = 8'(i);
      end
      @(posedge HCLK); #1;
      ld_valid = 1'b0; ld_end = 1'b1;
      @(posedge HCLK); #1 ld_end = 1'b0;
      @(negedge HCLK);
      chk("flush_busy", 32'(busy_a), 32'h1);
      chk("flush_ld_ready", 32'(ldr_a), 32'h0);
      chk("flush_words_before", 32'(words_a), 32'h1);
      @(negedge HCLK);
      chk("load5_busy", 32'(busy_a), 32'h0);
      chk("load5_words", 32'(words_a), 32'h2);
      chk("load5_ovf", 32'(ovf_a), 32'h0);
      chk("load5_chksum", 32'(sum_a), ck(32'h000F));
      rd_chk("r_ld_w0", 32'h0, 32'h04030201);
      rd_chk("r_ld_w1", 32'h4, 32'h00000005);
      rd_chk("r_ld_w2", 32'h8, 32'h00000000);
      rd_chk("r_ld_w15", 32'h3C, 32'h00000000);

      @(posedge HCLK); #1 ld_end = 1'b1;
      @(posedge HCLK); #1 ld_end = 1'b0;
      @(negedge HCLK);
      chk("end_in_idle", 32'(busy_a), 32'h0);

      // 300 x 0xFF with ld_end on the last byte: overflow and checksum wrap
      pulse_start();
      wait_ready("rdy_load300");
      for (int i = 0; i < 300; i++) begin
         @(posedge HCLK); #1;
         ld_valid = 1'b1; ld_data = 8'hFF; ld_end = (i == 299);
      end
      @(posedge HCLK); #1;
      ld_valid = 1'b0; ld_end = 1'b0;
      @(negedge HCLK);
      chk("ff300_busy", 32'(busy_a), 32'h0);
      chk("ff300_words", 32'(words_a), 32'd16);
      chk("ff300_ovf", 32'(ovf_a), 32'h1);
      chk("ff300_chksum", 32'(sum_a), ck(32'h2AD4));
      rd_chk("r_ff_w0", 32'h0, 32'hFFFFFFFF);
      rd_chk("r_ff_w15", 32'h3C, 32'hFFFFFFFF);

      // Instance B: two wait states per data phase
      sel = 1'b1; exp_ws = 2;
      wr("b_w0", 32'h0, HSIZE_WORD, 32'hA5A50001);
      wr("b_w4", 32'h4, HSIZE_WORD, 32'h0000B002);
      @(posedge HCLK); #1;
      hsel = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
      @(posedge HCLK); #1;
      HTRANS = HTRANS_SEQ; HADDR = 32'h4;
      w0 = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge HCLK);
         if (hro_b) break;
         w0++;
      end
      rd0 = hrd_b;
      @(posedge HCLK); #1;
      hsel = 1'b0; HTRANS = HTRANS_IDLE;
      w1 = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge HCLK);
         if (hro_b) break;
         w1++;
      end
      rd1 = hrd_b;
      chk("b2b_waits0", 32'(w0), 32'd2);
      chk("b2b_data0", rd0, 32'hA5A50001);
      chk("b2b_waits1", 32'(w1), 32'd2);
      chk("b2b_data1", rd1, 32'h0000B002);

      // Load at base 0x38: only words 14 and 15 fit; ld_start mid-load is ignored
      pulse_start();
      wait_ready("rdy_load_b");
      for (int i = 0; i < 12; i++) begin
         @(posedge HCLK); #1;
         ld_valid = 1'b1; ld_data = 8'(8'h10 + i); ld_start_b = (i == 5);
      end
      @(posedge HCLK); #1;
      ld_valid = 1'b0; ld_start_b = 1'b0; ld_end = 1'b1;
      @(posedge HCLK); #1 ld_end = 1'b0;
      @(negedge HCLK);
      chk("b_ld_busy", 32'(busy_b), 32'h0);
      chk("b_ld_words", 32'(words_b), 32'h2);
      chk("b_ld_ovf", 32'(ovf_b), 32'h1);
      chk("b_ld_chksum", 32'(sum_b), ck(32'h0102));
      rd_chk("b_r_w14", 32'h38, 32'h13121110);
      rd_chk("b_r_w15", 32'h3C, 32'h17161514);
      rd_chk("b_r_w0", 32'h0, 32'h00000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
